prt_dp_pm_hpd_cond: RTL

HPD input conditioner for the DP TX policy-maker. It sits directly upstream of the HPD TX event detector and feeds it the 1 MHz beat and a clean HPD level. Inside, it synchronises the raw HPD pin, generates the beat from CLK_IN, and runs a beat-based glitch filter. It also counts rejected glitches for debug.

---
 rtl/prt_dp_pm_hpd_cond.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/prt_dp_pm_hpd_cond.sv
// HPD conditioner: synchronises the raw pin, derives a 1 MHz beat from CLK_IN and
// accepts a level change only after T consecutive stable beats; rejected changes are counted.
module prt_dp_pm_hpd_cond #(
    parameter int P_SIM          = 0,
    parameter int P_CLK_FREQ_MHZ = 100,
    parameter int P_FILT_BEATS   = 8,
    parameter int P_SYNC_STAGES  = 2
) (
    input  logic       RST_IN,
    input  logic       CLK_IN,
    input  logic       HPD_PIN_IN,
    input  logic       GLITCH_CLR_IN,
    output logic       BEAT_OUT,
    output logic       HPD_OUT,
    output logic       HPD_RE_OUT,
    output logic       HPD_FE_OUT,
    output logic [7:0] GLITCH_CNT_OUT
);

    localparam int LP_T  = (P_SIM != 0) ? 2 : P_FILT_BEATS;
    localparam int LP_SW = $clog2(LP_T + 1);
    localparam int LP_DW = $clog2(P_CLK_FREQ_MHZ);

    localparam logic [LP_DW-1:0] LP_DIV_LAST = LP_DW'(P_CLK_FREQ_MHZ - 1);
    localparam logic [LP_DW-1:0] LP_DIV_HALF = LP_DW'(P_CLK_FREQ_MHZ / 2);
    localparam logic [LP_SW-1:0] LP_STB_LAST = LP_SW'(LP_T - 1);

    typedef enum logic [1:0] {
        SM_LOW      = 2'd0,
        SM_RISE_CHK = 2'd1,
        SM_HIGH     = 2'd2,
        SM_FALL_CHK = 2'd3
    } sm_t;

    logic [P_SYNC_STAGES-1:0] r_sync;
    logic [LP_DW-1:0]         r_div_cnt;
    logic                     r_beat;
    sm_t                      r_state;
    logic [LP_SW-1:0]         r_stable;
    logic                     r_hpd;
    logic                     r_hpd_re;
    logic                     r_hpd_fe;
    logic [7:0]               r_glitch_cnt;

    logic                     w_sync_hpd;
    logic [LP_DW-1:0]         w_div_nxt;
    logic                     w_tick;
    logic                     w_glitch_inc;

    assign w_sync_hpd = r_sync[P_SYNC_STAGES-1];
    assign w_tick     = (r_div_cnt == LP_DIV_LAST);
    assign w_div_nxt  = w_tick ? '0 : r_div_cnt + LP_DW'(1);

    // A level mismatch while checking aborts the candidate change, even on a tick.
    assign w_glitch_inc = ((r_state == SM_RISE_CHK) && !w_sync_hpd) ||
                          ((r_state == SM_FALL_CHK) &&  w_sync_hpd);

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[P_SYNC_STAGES-2:0], HPD_PIN_IN};
        end
    end

    // Beat is decoded from the next count so its rising edge follows the tick by one clock.
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            r_div_cnt <= '0;
            r_beat    <= 1'b0;
        end else begin
            r_div_cnt <= w_div_nxt;
            r_beat    <= (w_div_nxt < LP_DIV_HALF);
        end
    end

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            r_state  <= SM_LOW;
            r_stable <= '0;
            r_hpd    <= 1'b0;
            r_hpd_re <= 1'b0;
            r_hpd_fe <= 1'b0;
        end else begin
            r_hpd_re <= 1'b0;
            r_hpd_fe <= 1'b0;
            case (r_state)
                SM_LOW: begin
                    if (w_sync_hpd) begin
                        r_state  <= SM_RISE_CHK;
                        r_stable <= '0;
                    end
                end
                SM_RISE_CHK: begin
                    if (!w_sync_hpd) begin
                        r_state <= SM_LOW;
                    end else if (w_tick) begin
                        if (r_stable == LP_STB_LAST) begin
                            r_state  <= SM_HIGH;
                            r_hpd    <= 1'b1;
                            r_hpd_re <= 1'b1;
                        end else begin
                            r_stable <= r_stable + LP_SW'(1);
                        end
                    end
                end
                SM_HIGH: begin
                    if (!w_sync_hpd) begin
                        r_state  <= SM_FALL_CHK;
                        r_stable <= '0;
                    end
                end
                SM_FALL_CHK: begin
                    if (w_sync_hpd) begin
                        r_state <= SM_HIGH;
                    end else if (w_tick) begin
                        if (r_stable == LP_STB_LAST) begin
                            r_state  <= SM_LOW;
                            r_hpd    <= 1'b0;
                            r_hpd_fe <= 1'b1;
                        end else begin
                            r_stable <= r_stable + LP_SW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= SM_LOW;
                end
            endcase
        end
    end

    // Clear has priority over a same-cycle increment; the count sticks at 255.
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            r_glitch_cnt <= 8'd0;
        end else if (GLITCH_CLR_IN) begin
            r_glitch_cnt <= 8'd0;
        end else if (w_glitch_inc && (r_glitch_cnt != 8'hFF)) begin
            r_glitch_cnt <= r_glitch_cnt + 8'd1;
        end
    end

    assign BEAT_OUT       = r_beat;
    assign HPD_OUT        = r_hpd;
    assign HPD_RE_OUT     = r_hpd_re;
    assign HPD_FE_OUT     = r_hpd_fe;
    assign GLITCH_CNT_OUT = r_glitch_cnt;

endmodule
